// File: rtl/register_file_mp.sv
// Multi-ported register file: 2 combinational read ports, 2 write ports, per-register pending (busy) scoreboard.
// Latency: reads are 0 cycles (optional same-cycle write forwarding), writes and issues commit on the next rising edge.
// Backpressure: none; every write, issue and read is accepted unconditionally in the cycle it is presented.
module register_file_mp #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREGS    = 32,
  parameter int unsigned     SP_INDEX = 2,
  parameter logic [XLEN-1:0] SP_INIT  = XLEN'(32'h0100_0000),
  parameter bit              BYPASS   = 1'b1,
  localparam int unsigned    AW       = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   addr_rs1,
  input  logic [AW-1:0]   addr_rs2,
  output logic [XLEN-1:0] data_rs1,
  output logic [XLEN-1:0] data_rs2,
  output logic            busy_rs1,
  output logic            busy_rs2,
  input  logic            we0,
  input  logic [AW-1:0]   addr_rd0,
  input  logic [XLEN-1:0] data_rd0,
  input  logic            we1,
  input  logic [AW-1:0]   addr_rd1,
  input  logic [XLEN-1:0] data_rd1,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic wr0_act;
  logic wr1_act;
  logic iss_act;

  logic [AW-1:0]   rs_addr [2];
  logic [XLEN-1:0] rs_data [2];
  logic            rs_busy [2];

  assign rs_addr[0] = addr_rs1;
  assign rs_addr[1] = addr_rs2;

  assign data_rs1 = rs_data[0];
  assign data_rs2 = rs_data[1];
  assign busy_rs1 = rs_busy[0];
  assign busy_rs2 = rs_busy[1];

  // Effective write/issue strobes: x0 is never a target and reset masks every event.
  always_comb begin
    wr0_act = we0 && (addr_rd0 != '0) && !reset;
    wr1_act = we1 && (addr_rd1 != '0) && !reset;
    iss_act = issue_valid && (issue_rd != '0) && !reset;
  end

  // Next array contents: port 1 is applied last so it wins a same-address collision.
  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr0_act) begin
      regs_d[addr_rd0] = data_rd0;
    end
    if (wr1_act) begin
      regs_d[addr_rd1] = data_rd1;
    end
    regs_d[0] = '0;
  end

  // Next busy bits: writeback clears, issue sets afterwards so it wins a same-cycle collision.
  always_comb begin
    busy_d = busy_q;
    if (wr0_act) begin
      busy_d[addr_rd0] = 1'b0;
    end
    if (wr1_act) begin
      busy_d[addr_rd1] = 1'b0;
    end
    if (iss_act) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Array state; reset loads zero everywhere except the stack pointer register.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= ((i == SP_INDEX) && (i != 0)) ? SP_INIT : '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Scoreboard state; reset drops every pending writeback.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Read ports: array value, optionally overridden by in-flight write data; x0 is hardwired to zero/idle.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rs_data[p] = regs_q[rs_addr[p]];
      rs_busy[p] = busy_q[rs_addr[p]];
      if (BYPASS) begin
        if (wr1_act && (addr_rd1 == rs_addr[p])) begin
          rs_data[p] = data_rd1;
        end else if (wr0_act && (addr_rd0 == rs_addr[p])) begin
          rs_data[p] = data_rd0;
        end
        // A register being written back is no longer pending unless it is re-issued this same cycle.
        if (((wr0_act && (addr_rd0 == rs_addr[p])) || (wr1_act && (addr_rd1 == rs_addr[p])))
            && !(iss_act && (issue_rd == rs_addr[p]))) begin
          rs_busy[p] = 1'b0;
        end
      end
      if (rs_addr[p] == '0) begin
        rs_data[p] = '0;
        rs_busy[p] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp: a forwarding instance and a non-forwarding instance share all inputs.
// Expectations are queued when a cycle's stimulus is applied and drained against the DUT outputs before the edge.
// Directed cases cover reset, forwarding, write collisions, busy tracking, x0 and mid-run reset; a random phase follows.
module tb_register_file_mp;

  localparam int AW = 5;
  localparam logic [31:0] SP_VAL = 32'h0100_0000;

  logic          clock;
  logic          reset;
  logic [AW-1:0] addr_rs1, addr_rs2;
  logic          we0, we1, issue_valid;
  logic [AW-1:0] addr_rd0, addr_rd1, issue_rd;
  logic [31:0]   data_rd0, data_rd1;

  logic [31:0]   data_rs1, data_rs2, nb_data_rs1, nb_data_rs2;
  logic          busy_rs1, busy_rs2, nb_busy_rs1, nb_busy_rs2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          src;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];

  logic [31:0] mdl_regs [32];
  logic        mdl_busy [32];

  register_file_mp #(.BYPASS(1'b1)) dut (
    .clock(clock), .reset(reset),
    .addr_rs1(addr_rs1), .addr_rs2(addr_rs2),
    .data_rs1(data_rs1), .data_rs2(data_rs2),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
    .we0(we0), .addr_rd0(addr_rd0), .data_rd0(data_rd0),
    .we1(we1), .addr_rd1(addr_rd1), .data_rd1(data_rd1),
    .issue_valid(issue_valid), .issue_rd(issue_rd)
  );

  register_file_mp #(.BYPASS(1'b0)) dut_nb (
    .clock(clock), .reset(reset),
    .addr_rs1(addr_rs1), .addr_rs2(addr_rs2),
    .data_rs1(nb_data_rs1), .data_rs2(nb_data_rs2),
    .busy_rs1(nb_busy_rs1), .busy_rs2(nb_busy_rs2),
    .we0(we0), .addr_rd0(addr_rd0), .data_rd0(data_rd0),
    .we1(we1), .addr_rd1(addr_rd1), .data_rd1(data_rd1),
    .issue_valid(issue_valid), .issue_rd(issue_rd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic expect_val(input string tag, input int src, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.src = src;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int src);
    case (src)
      0:       return data_rs1;
      1:       return data_rs2;
      2:       return {31'd0, busy_rs1};
      3:       return {31'd0, busy_rs2};
      4:       return nb_data_rs1;
      5:       return nb_data_rs2;
      6:       return {31'd0, nb_busy_rs1};
      default: return {31'd0, nb_busy_rs2};
    endcase
  endfunction

  // Called shortly after a rising edge with this cycle's inputs applied; samples mid-cycle, then moves past the next edge.
  task automatic step();
    exp_t e;
    #3;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.src), e.exp);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; addr_rd0 = '0; data_rd0 = '0;
    we1 = 1'b0; addr_rd1 = '0; data_rd1 = '0;
    issue_valid = 1'b0; issue_rd = '0;
  endtask

  // Pushes an expectation for all eight outputs at once.
  task automatic expect_all(input string tag, input logic [31:0] d1, input logic [31:0] d2,
                            input logic b1, input logic b2, input logic [31:0] nd1,
                            input logic [31:0] nd2, input logic nb1, input logic nb2);
    expect_val({tag, "_d1"}, 0, d1);
    expect_val({tag, "_d2"}, 1, d2);
    expect_val({tag, "_b1"}, 2, {31'd0, b1});
    expect_val({tag, "_b2"}, 3, {31'd0, b2});
    expect_val({tag, "_nd1"}, 4, nd1);
    expect_val({tag, "_nd2"}, 5, nd2);
    expect_val({tag, "_nb1"}, 6, {31'd0, nb1});
    expect_val({tag, "_nb2"}, 7, {31'd0, nb2});
  endtask

  function automatic logic [31:0] mdl_data(input logic [AW-1:0] a, input bit byp);
    if (a == '0) return 32'd0;
    if (byp && we1 && (addr_rd1 == a)) return data_rd1;
    if (byp && we0 && (addr_rd0 == a)) return data_rd0;
    return mdl_regs[a];
  endfunction

  function automatic logic mdl_busy_rd(input logic [AW-1:0] a, input bit byp);
    if (a == '0) return 1'b0;
    if (byp && ((we0 && (addr_rd0 == a)) || (we1 && (addr_rd1 == a)))
        && !(issue_valid && (issue_rd == a))) return 1'b0;
    return mdl_busy[a];
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, 31));
  endfunction

  initial begin
    reset = 1'b1;
    addr_rs1 = '0;
    addr_rs2 = '0;
    idle();
    @(posedge clock);
    #1;
    step();

    // Reset values visible from the first cycle.
    reset = 1'b0;
    addr_rs1 = 5'd2; addr_rs2 = 5'd5;
    expect_all("rst", SP_VAL, 0, 0, 0, SP_VAL, 0, 0, 0);
    step();

    // Same-cycle forwarding on x7.
    addr_rs1 = 5'd7; addr_rs2 = 5'd2;
    we0 = 1'b1; addr_rd0 = 5'd7; data_rd0 = 32'hDEAD_BEEF;
    expect_all("fwd", 32'hDEAD_BEEF, SP_VAL, 0, 0, 32'd0, SP_VAL, 0, 0);
    step();
    idle();
    expect_all("fwd_post", 32'hDEAD_BEEF, SP_VAL, 0, 0, 32'hDEAD_BEEF, SP_VAL, 0, 0);
    step();

    // Both ports write x9: port 1 wins both in forwarding and in the array.
    addr_rs1 = 5'd9; addr_rs2 = 5'd7;
    we0 = 1'b1; addr_rd0 = 5'd9; data_rd0 = 32'h1111;
    we1 = 1'b1; addr_rd1 = 5'd9; data_rd1 = 32'h2222;
    expect_all("coll", 32'h2222, 32'hDEAD_BEEF, 0, 0, 32'd0, 32'hDEAD_BEEF, 0, 0);
    step();
    idle();
    expect_all("coll_post", 32'h2222, 32'hDEAD_BEEF, 0, 0, 32'h2222, 32'hDEAD_BEEF, 0, 0);
    step();

    // Issue x4, hold busy over idle cycles, then clear by writeback.
    addr_rs1 = 5'd4; addr_rs2 = 5'd0;
    issue_valid = 1'b1; issue_rd = 5'd4;
    expect_all("iss", 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    idle();
    for (int k = 0; k < 3; k++) begin
      expect_all($sformatf("iss_hold%0d", k), 0, 0, 1, 0, 0, 0, 1, 0);
      step();
    end
    we1 = 1'b1; addr_rd1 = 5'd4; data_rd1 = 32'h44;
    expect_all("wb", 32'h44, 0, 0, 0, 0, 0, 1, 0);
    step();
    idle();
    expect_all("wb_post", 32'h44, 0, 0, 0, 32'h44, 0, 0, 0);
    step();

    // Issue and write x4 together: issue wins.
    issue_valid = 1'b1; issue_rd = 5'd4;
    we0 = 1'b1; addr_rd0 = 5'd4; data_rd0 = 32'h55;
    expect_all("iss_wb", 32'h55, 0, 0, 0, 32'h44, 0, 0, 0);
    step();
    idle();
    expect_all("iss_wb_post", 32'h55, 0, 1, 0, 32'h55, 0, 1, 0);
    step();

    // x0 ignores writes and issues.
    addr_rs1 = 5'd0; addr_rs2 = 5'd4;
    we0 = 1'b1; addr_rd0 = 5'd0; data_rd0 = 32'hFFFF_FFFF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    expect_all("x0", 0, 32'h55, 0, 1, 0, 32'h55, 0, 1);
    step();
    idle();
    expect_all("x0_post", 0, 32'h55, 0, 1, 0, 32'h55, 0, 1);
    step();

    // Mid-run reset discards pending state and contents; events during reset are ignored.
    issue_valid = 1'b1; issue_rd = 5'd3;
    we0 = 1'b1; addr_rd0 = 5'd6; data_rd0 = 32'd5;
    step();
    idle();
    addr_rs1 = 5'd3; addr_rs2 = 5'd6;
    expect_all("pre_rst", 0, 32'd5, 1, 0, 0, 32'd5, 1, 0);
    step();
    reset = 1'b1;
    we0 = 1'b1; addr_rd0 = 5'd6; data_rd0 = 32'd9;
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    reset = 1'b0;
    idle();
    expect_all("mid_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    addr_rs1 = 5'd2; addr_rs2 = 5'd7;
    expect_all("mid_rst_sp", SP_VAL, 0, 0, 0, SP_VAL, 0, 0, 0);
    step();

    // Random phase against a behavioural model starting from the reset state.
    for (int i = 0; i < 32; i++) begin
      mdl_regs[i] = (i == 2) ? SP_VAL : 32'd0;
      mdl_busy[i] = 1'b0;
    end
    for (int n = 0; n < 300; n++) begin
      addr_rs1 = rand_addr();
      addr_rs2 = rand_addr();
      we0 = 1'($urandom_range(0, 1));
      addr_rd0 = rand_addr();
      data_rd0 = $urandom;
      we1 = 1'($urandom_range(0, 1));
      addr_rd1 = rand_addr();
      data_rd1 = $urandom;
      issue_valid = 1'($urandom_range(0, 2) == 0);
      issue_rd = rand_addr();
      expect_all($sformatf("rnd%0d", n),
                 mdl_data(addr_rs1, 1'b1), mdl_data(addr_rs2, 1'b1),
                 mdl_busy_rd(addr_rs1, 1'b1), mdl_busy_rd(addr_rs2, 1'b1),
                 mdl_data(addr_rs1, 1'b0), mdl_data(addr_rs2, 1'b0),
                 mdl_busy_rd(addr_rs1, 1'b0), mdl_busy_rd(addr_rs2, 1'b0));
      if (we0 && addr_rd0 != '0) begin
        mdl_regs[addr_rd0] = data_rd0;
        mdl_busy[addr_rd0] = 1'b0;
      end
      if (we1 && addr_rd1 != '0) begin
        mdl_regs[addr_rd1] = data_rd1;
        mdl_busy[addr_rd1] = 1'b0;
      end
      if (issue_valid && issue_rd != '0) begin
        mdl_busy[issue_rd] = 1'b1;
      end
      step();
    end

    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
